// File: rtl/flash_cmd_pkg.sv
// rtl/flash_cmd_pkg.sv - SPI flash command codes, sequencer states and timing helpers
package flash_cmd_pkg;

    localparam logic [7:0] CMD_WAKE   = 8'hAB;
    localparam logic [7:0] CMD_READ3  = 8'h03;
    localparam logic [7:0] CMD_FAST3  = 8'h0B;
    localparam logic [7:0] CMD_READ4  = 8'h13;
    localparam logic [7:0] CMD_FAST4  = 8'h0C;
    localparam logic [7:0] DUMMY_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAKE_TX,
        ST_WAKE_GAP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_FINISH
    } state_t;

    function automatic int half_clks(input int clk_hz, input int spi_hz);
        int h;
        h = clk_hz / spi_hz / 2;
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int wake_cycles(input int clk_hz, input int wait_us);
        longint prod;
        prod = longint'(wait_us) * longint'(clk_hz) + longint'(999999);
        return int'(prod / longint'(1000000));
    endfunction

endpackage

// File: rtl/flash_spi_byte_engine.sv
// rtl/flash_spi_byte_engine.sv - mode-3 SPI byte shifter: MOSI on falling edge, MISO sampled on rising
module flash_spi_byte_engine
    import flash_cmd_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 25000000,
    parameter int SPI_CLOCK_HZ  = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    output logic       idle_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_done_o,
    output logic       spi_clk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i
);

    localparam int HALF = half_clks(CLOCK_FREQ_HZ, SPI_CLOCK_HZ);
    localparam int TW   = $clog2(HALF + 1);
    localparam logic [TW-1:0] T_LOAD = TW'(HALF - 1);

    logic          busy_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_q;
    logic [7:0]    tx_sh_q;
    logic [7:0]    rx_sh_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          rx_done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q    <= 1'b0;
            timer_q   <= '0;
            bit_q     <= 3'd0;
            tx_sh_q   <= 8'hFF;
            rx_sh_q   <= 8'hFF;
            sclk_q    <= 1'b1;
            mosi_q    <= 1'b1;
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            if (!busy_q) begin
                if (start_i) begin
                    busy_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    mosi_q  <= tx_byte_i[7];
                    tx_sh_q <= {tx_byte_i[6:0], 1'b1};
                    bit_q   <= 3'd0;
                    timer_q <= T_LOAD;
                end
            end else if (timer_q != '0) begin
                timer_q <= timer_q - TW'(1);
            end else if (!sclk_q) begin
                sclk_q  <= 1'b1;
                rx_sh_q <= {rx_sh_q[6:0], spi_miso_i};
                timer_q <= T_LOAD;
            end else if (bit_q == 3'd7) begin
                // Byte ends after the high half of bit 0, leaving the clock parked high.
                busy_q    <= 1'b0;
                rx_done_q <= 1'b1;
                mosi_q    <= 1'b1;
            end else begin
                sclk_q  <= 1'b0;
                mosi_q  <= tx_sh_q[7];
                tx_sh_q <= {tx_sh_q[6:0], 1'b1};
                bit_q   <= bit_q + 3'd1;
                timer_q <= T_LOAD;
            end
        end
    end

    assign idle_o     = !busy_q;
    assign rx_byte_o  = rx_sh_q;
    assign rx_done_o  = rx_done_q;
    assign spi_clk_o  = sclk_q;
    assign spi_mosi_o = mosi_q;

endmodule

// File: rtl/flash_stream_reader.sv
// rtl/flash_stream_reader.sv - request-driven SPI flash range reader streaming bytes with backpressure
module flash_stream_reader
    import flash_cmd_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 25000000,
    parameter int SPI_CLOCK_HZ  = 1000000,
    parameter int ADDR_BYTES    = 3,
    parameter int FAST_READ     = 0,
    parameter int WAKE_ENABLE   = 1,
    parameter int WAKE_WAIT_US  = 35,
    parameter int LEN_WIDTH     = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [8*ADDR_BYTES-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]    req_len,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    spi_clk,
    output logic                    spi_cs_n,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);

    localparam int AW       = 8 * ADDR_BYTES;
    localparam int HALF     = half_clks(CLOCK_FREQ_HZ, SPI_CLOCK_HZ);
    localparam int FIN_W    = $clog2(HALF + 1);
    localparam int WAKE_CYC = wake_cycles(CLOCK_FREQ_HZ, WAKE_WAIT_US);
    localparam int GAP_W    = $clog2(WAKE_CYC + 2);
    localparam logic [FIN_W-1:0] FIN_LOAD = FIN_W'(HALF - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((WAKE_CYC > 0) ? WAKE_CYC - 1 : 0);
    localparam logic [7:0] READ_CMD = (ADDR_BYTES == 4) ? ((FAST_READ != 0) ? CMD_FAST4 : CMD_READ4)
                                                        : ((FAST_READ != 0) ? CMD_FAST3 : CMD_READ3);

    state_t               state_q;
    logic                 cs_n_q, busy_q, done_q, req_ready_q;
    logic                 tvalid_q;
    logic [7:0]           tdata_q;
    logic                 start_q;
    logic [7:0]           tx_q;
    logic [AW-1:0]        addr_q;
    logic [1:0]           idx_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic [FIN_W-1:0]     fin_q;
    logic [GAP_W-1:0]     gap_q;
    logic                 wake_done_q, abort_q;

    logic       eng_idle, eng_rx_done, eng_free, abort_now;
    logic [7:0] eng_rx_byte;

    flash_spi_byte_engine #(
        .CLOCK_FREQ_HZ(CLOCK_FREQ_HZ),
        .SPI_CLOCK_HZ (SPI_CLOCK_HZ)
    ) u_engine (
        .clock     (clock),
        .reset     (reset),
        .start_i   (start_q),
        .tx_byte_i (tx_q),
        .idle_o    (eng_idle),
        .rx_byte_o (eng_rx_byte),
        .rx_done_o (eng_rx_done),
        .spi_clk_o (spi_clk),
        .spi_mosi_o(spi_mosi),
        .spi_miso_i(spi_miso)
    );

    // A start issued last cycle has not yet reached the engine's busy flag.
    assign eng_free  = eng_idle && !start_q;
    assign abort_now = abort_q || abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= 8'hFF;
            start_q     <= 1'b0;
            tx_q        <= 8'hFF;
            addr_q      <= '0;
            idx_q       <= 2'd0;
            remaining_q <= '0;
            fin_q       <= '0;
            gap_q       <= '0;
            wake_done_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q != ST_IDLE && abort) abort_q <= 1'b1;

            if (state_q != ST_IDLE && abort_now) begin
                tvalid_q <= 1'b0;
            end else if (state_q == ST_DATA && eng_rx_done) begin
                tdata_q  <= eng_rx_byte;
                tvalid_q <= 1'b1;
            end else if (tvalid_q && m_tready) begin
                tvalid_q <= 1'b0;
            end

            if (state_q != ST_IDLE && state_q != ST_FINISH && abort_now && eng_free) begin
                state_q <= ST_FINISH;
                cs_n_q  <= 1'b1;
                fin_q   <= FIN_LOAD;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        req_ready_q <= 1'b1;
                        abort_q     <= 1'b0;
                        if (req_valid && req_ready_q) begin
                            req_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            addr_q      <= req_addr;
                            remaining_q <= req_len;
                            if (req_len == '0) begin
                                state_q <= ST_FINISH;
                                fin_q   <= '0;
                            end else if (WAKE_ENABLE != 0 && !wake_done_q) begin
                                state_q <= ST_WAKE_TX;
                                cs_n_q  <= 1'b0;
                                start_q <= 1'b1;
                                tx_q    <= CMD_WAKE;
                            end else begin
                                state_q <= ST_CMD;
                                cs_n_q  <= 1'b0;
                                start_q <= 1'b1;
                                tx_q    <= READ_CMD;
                            end
                        end
                    end
                    ST_WAKE_TX: if (eng_rx_done) begin
                        state_q <= ST_WAKE_GAP;
                        cs_n_q  <= 1'b1;
                        gap_q   <= GAP_LOAD;
                    end
                    ST_WAKE_GAP: begin
                        if (gap_q == '0) begin
                            wake_done_q <= 1'b1;
                            state_q     <= ST_CMD;
                            cs_n_q      <= 1'b0;
                            start_q     <= 1'b1;
                            tx_q        <= READ_CMD;
                        end else begin
                            gap_q <= gap_q - GAP_W'(1);
                        end
                    end
                    ST_CMD: if (eng_rx_done) begin
                        state_q <= ST_ADDR;
                        idx_q   <= 2'(ADDR_BYTES - 1);
                        start_q <= 1'b1;
                        tx_q    <= addr_q[AW-1 -: 8];
                        addr_q  <= addr_q << 8;
                    end
                    ST_ADDR: if (eng_rx_done) begin
                        if (idx_q != 2'd0) begin
                            idx_q   <= idx_q - 2'd1;
                            start_q <= 1'b1;
                            tx_q    <= addr_q[AW-1 -: 8];
                            addr_q  <= addr_q << 8;
                        end else if (FAST_READ != 0) begin
                            state_q <= ST_DUMMY;
                            start_q <= 1'b1;
                            tx_q    <= DUMMY_BYTE;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DUMMY: if (eng_rx_done) state_q <= ST_DATA;
                    ST_DATA: begin
                        // Hold off the next byte until the output register is guaranteed free.
                        if (remaining_q != '0) begin
                            if (eng_free && !eng_rx_done && (!tvalid_q || m_tready)) begin
                                start_q     <= 1'b1;
                                tx_q        <= DUMMY_BYTE;
                                remaining_q <= remaining_q - LEN_WIDTH'(1);
                            end
                        end else if (eng_free) begin
                            state_q <= ST_FINISH;
                            cs_n_q  <= 1'b1;
                            fin_q   <= FIN_LOAD;
                        end
                    end
                    ST_FINISH: begin
                        if (fin_q != '0) begin
                            fin_q <= fin_q - FIN_W'(1);
                        end else if (!tvalid_q) begin
                            state_q     <= ST_IDLE;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            req_ready_q <= 1'b1;
                            abort_q     <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign m_tdata   = tdata_q;
    assign m_tvalid  = tvalid_q;
    assign spi_cs_n  = cs_n_q;

endmodule

// File: tb/tb_flash_stream_reader.sv
// tb/tb_flash_stream_reader.sv - directed self-checking bench with behavioural SPI flash models
module tb_flash_stream_reader;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // DUT A: default parameters (3-byte address, READ, wake enabled)
    logic        req_valid_a = 1'b0, req_ready_a, abort_a = 1'b0, busy_a, done_a;
    logic [23:0] req_addr_a = '0, req_len_a = '0;
    logic [7:0]  tdata_a;
    logic        tvalid_a, tready_a = 1'b1, sclk_a, cs_n_a, mosi_a, miso_a = 1'b1;

    // DUT B: FAST_READ with 4-byte addressing, no wake
    logic        req_valid_b = 1'b0, req_ready_b, abort_b = 1'b0, busy_b, done_b;
    logic [31:0] req_addr_b = '0;
    logic [23:0] req_len_b = '0;
    logic [7:0]  tdata_b;
    logic        tvalid_b, tready_b = 1'b1, sclk_b, cs_n_b, mosi_b, miso_b = 1'b1;

    flash_stream_reader u_dut_a (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a), .req_len(req_len_a),
        .abort(abort_a), .busy(busy_a), .done(done_a),
        .m_tdata(tdata_a), .m_tvalid(tvalid_a), .m_tready(tready_a),
        .spi_clk(sclk_a), .spi_cs_n(cs_n_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
    );

    flash_stream_reader #(.ADDR_BYTES(4), .FAST_READ(1), .WAKE_ENABLE(0)) u_dut_b (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b), .req_len(req_len_b),
        .abort(abort_b), .busy(busy_b), .done(done_b),
        .m_tdata(tdata_b), .m_tvalid(tvalid_b), .m_tready(tready_b),
        .spi_clk(sclk_b), .spi_cs_n(cs_n_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
    );

    // Flash models: log every MOSI byte, return data[] after hdr header bytes
    logic [7:0] log_a[$], log_b[$], data_a[$], data_b[$], out_a[$], out_b[$];
    logic [7:0] sh_a, sh_b;
    int bits_a = 0, bits_b = 0, hdr_a = 4, hdr_b = 6, nm_a, nm_b;
    int run_a = 0, cs_low_a = 0, done_cnt_a = 0, done_cnt_b = 0;
    int gaps_a[$];

    always @(posedge cs_n_a) bits_a = 0;
    always @(posedge sclk_a) if (!cs_n_a) begin
        sh_a = {sh_a[6:0], mosi_a};
        bits_a++;
        if (bits_a % 8 == 0) log_a.push_back(sh_a);
    end
    always @(negedge sclk_a) if (!cs_n_a) begin
        nm_a = bits_a / 8 - hdr_a;
        miso_a = (nm_a >= 0 && nm_a < data_a.size()) ? data_a[nm_a][7 - (bits_a % 8)] : 1'b1;
    end

    always @(posedge cs_n_b) bits_b = 0;
    always @(posedge sclk_b) if (!cs_n_b) begin
        sh_b = {sh_b[6:0], mosi_b};
        bits_b++;
        if (bits_b % 8 == 0) log_b.push_back(sh_b);
    end
    always @(negedge sclk_b) if (!cs_n_b) begin
        nm_b = bits_b / 8 - hdr_b;
        miso_b = (nm_b >= 0 && nm_b < data_b.size()) ? data_b[nm_b][7 - (bits_b % 8)] : 1'b1;
    end

    always @(negedge clock) begin
        if (tvalid_a && tready_a) out_a.push_back(tdata_a);
        if (tvalid_b && tready_b) out_b.push_back(tdata_b);
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (cs_n_a) run_a++;
        else begin
            if (run_a > 0) gaps_a.push_back(run_a);
            run_a = 0;
            cs_low_a++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic wait_done(input bit use_b, input string tag);
        int n;
        n = 0;
        while (!(use_b ? done_b : done_a) && n < 20000) begin
            tick(1);
            n++;
        end
        chk({tag, "_done_seen"}, (n < 20000), 1);
    endtask

    task automatic req_a(input logic [23:0] addr, input logic [23:0] len);
        req_addr_a  = addr;
        req_len_a   = len;
        req_valid_a = 1'b1;
        tick(1);
        req_valid_a = 1'b0;
    endtask

    initial begin
        logic [7:0] exp[$];
        int n, bad;

        // Reset values while reset is held
        tick(2);
        chk("rst_sclk", sclk_a, 1);
        chk("rst_cs_n", cs_n_a, 1);
        chk("rst_mosi", mosi_a, 1);
        chk("rst_tvalid", tvalid_a, 0);
        chk("rst_tdata", tdata_a, 8'hFF);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_req_ready", req_ready_a, 0);
        reset = 1'b0;
        tick(1);
        chk("idle_req_ready", req_ready_a, 1);

        // Basic read with wake-up
        data_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        log_a.delete(); out_a.delete(); gaps_a.delete(); done_cnt_a = 0;
        req_a(24'h020FBC, 24'd4);
        chk("t1_busy", busy_a, 1);
        chk("t1_ready_low", req_ready_a, 0);
        wait_done(0, "t1");
        chk("t1_busy_clear", busy_a, 0);
        tick(3);
        exp = '{8'hAB, 8'h03, 8'h02, 8'h0F, 8'hBC, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        cmp_bytes("t1_mosi", log_a, exp);
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        cmp_bytes("t1_out", out_a, exp);
        chk("t1_gap_count", (gaps_a.size() >= 2), 1);
        chk("t1_wake_gap", (gaps_a.size() >= 2) ? gaps_a[1] : -1, 875);
        chk("t1_done_pulses", done_cnt_a, 1);

        // Second request: no wake command
        data_a = '{8'h5A};
        log_a.delete(); out_a.delete(); done_cnt_a = 0;
        req_a(24'h000000, 24'd1);
        wait_done(0, "t2");
        tick(3);
        exp = '{8'h03, 8'h00, 8'h00, 8'h00, 8'hFF};
        cmp_bytes("t2_mosi", log_a, exp);
        exp = '{8'h5A};
        cmp_bytes("t2_out", out_a, exp);

        // FAST_READ, 4-byte address
        data_b = '{8'h5C, 8'hC5};
        log_b.delete(); out_b.delete(); done_cnt_b = 0;
        req_addr_b = 32'h01020304; req_len_b = 24'd2; req_valid_b = 1'b1;
        tick(1);
        req_valid_b = 1'b0;
        wait_done(1, "t3");
        tick(3);
        exp = '{8'h0C, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF};
        cmp_bytes("t3_mosi", log_b, exp);
        exp = '{8'h5C, 8'hC5};
        cmp_bytes("t3_out", out_b, exp);
        chk("t3_done_pulses", done_cnt_b, 1);

        // Backpressure: consumer stalls 200 cycles on the first byte
        data_a = '{8'hA1, 8'hB2, 8'hC3};
        out_a.delete(); done_cnt_a = 0;
        tready_a = 1'b0;
        req_a(24'h000100, 24'd3);
        n = 0;
        while (!tvalid_a && n < 5000) begin tick(1); n++; end
        chk("t4_first_valid", tvalid_a, 1);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (!(sclk_a === 1'b1 && cs_n_a === 1'b0 && tdata_a === 8'hA1 && tvalid_a === 1'b1)) bad++;
        end
        chk("t4_stall_stable", bad, 0);
        chk("t4_no_early_done", done_cnt_a, 0);
        tready_a = 1'b1;
        wait_done(0, "t4");
        tick(3);
        exp = '{8'hA1, 8'hB2, 8'hC3};
        cmp_bytes("t4_out", out_a, exp);

        // Zero length
        cs_low_a = 0; done_cnt_a = 0;
        req_a(24'h001234, 24'd0);
        chk("t5_busy", busy_a, 1);
        chk("t5_done_early", done_a, 0);
        tick(1);
        chk("t5_done", done_a, 1);
        tick(3);
        chk("t5_cs_never_low", cs_low_a, 0);
        chk("t5_done_pulses", done_cnt_a, 1);

        // Abort during the second data byte of ten
        data_a = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        log_a.delete(); out_a.delete(); done_cnt_a = 0;
        req_a(24'h000200, 24'd10);
        n = 0;
        while (out_a.size() < 1 && n < 5000) begin tick(1); n++; end
        chk("t6_first_byte", out_a.size(), 1);
        tick(20);
        abort_a = 1'b1;
        tick(1);
        abort_a = 1'b0;
        wait_done(0, "t6");
        tick(50);
        chk("t6_done_pulses", done_cnt_a, 1);
        chk("t6_out_at_most_2", (out_a.size() <= 2), 1);
        chk("t6_mosi_bytes", log_a.size(), 6);
        chk("t6_cs_high", cs_n_a, 1);

        // Reset in the middle of the address phase
        log_a.delete();
        req_a(24'h123456, 24'd2);
        n = 0;
        while (log_a.size() < 1 && n < 2000) begin tick(1); n++; end
        chk("t7_cmd_sent", log_a.size(), 1);
        tick(30);
        reset = 1'b1;
        tick(1);
        chk("t7_cs_high", cs_n_a, 1);
        chk("t7_sclk_high", sclk_a, 1);
        chk("t7_busy_low", busy_a, 0);
        reset = 1'b0;
        tick(1);
        data_a = '{8'h77};
        log_a.delete(); out_a.delete();
        req_a(24'h000000, 24'd1);
        wait_done(0, "t7");
        tick(3);
        exp = '{8'hAB, 8'h03, 8'h00, 8'h00, 8'h00, 8'hFF};
        cmp_bytes("t7_mosi", log_a, exp);
        exp = '{8'h77};
        cmp_bytes("t7_out", out_a, exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
